// File: rtl/prbs32_checker.sv
// prbs32_checker
//   Self-synchronising checker for the 32-bit PRBS word stream from the PHY
//   LFSR generator. Received words seed a local predictor. After LOCK_COUNT
//   consecutive correct predictions the checker locks. While locked, the
//   prediction free-runs and word/bit errors are counted.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   in_data        received 32-bit word
//   in_valid       in_data carries a stream word; when low all state holds
//   clear_counts   synchronous clear of the statistics counters (wins over increments)
//   locked         checker is in LOCKED
//   err_pulse      previous cycle's valid word mismatched while LOCKED
//   err_word_count mismatched words while LOCKED (saturating)
//   err_bit_count  mismatched bits while LOCKED (saturating)
//   word_count     valid words checked while LOCKED (saturating)
module prbs32_checker #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_word_count,
  output logic [CNT_W-1:0] err_bit_count,
  output logic [CNT_W-1:0] word_count
);

  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int UCW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_W+5:0] CNT_MAX_EXT = {6'b0, {CNT_W{1'b1}}};

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [31:0]      pred_base, pred_n;
  logic             have_base, have_n;
  logic [MCW-1:0]   match_cnt, match_n, match_inc;
  logic [UCW-1:0]   miss_cnt, miss_n, miss_inc;
  logic [CNT_W-1:0] ew_n, eb_n, wc_n;
  logic             pulse_n;

  logic [31:0]      expected;
  logic [31:0]      diff;
  logic             match;
  logic [5:0]       bitcnt;
  logic [CNT_W+5:0] bit_sum;

  // Next word of the generator's LFSR relation.
  assign expected  = {pred_base[30:0],
                      pred_base[30] ^ pred_base[28] ^ pred_base[24] ^ pred_base[23]};
  assign diff      = in_data ^ expected;
  // All-zero is the generator's lock-up fixed point, so it never counts as a match.
  assign match     = have_base && (in_data == expected) && (in_data != '0);
  assign match_inc = match_cnt + MCW'(1);
  assign miss_inc  = miss_cnt + UCW'(1);
  assign bit_sum   = {6'b0, err_bit_count} + (CNT_W + 6)'(bitcnt);
  assign locked    = (state == LOCKED);

  always_comb begin
    bitcnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      bitcnt = bitcnt + 6'(diff[i]);
    end
  end

  always_comb begin
    state_n = state;
    pred_n  = pred_base;
    have_n  = have_base;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    ew_n    = err_word_count;
    eb_n    = err_bit_count;
    wc_n    = word_count;
    pulse_n = 1'b0;

    if (in_valid) begin
      case (state)
        HUNT: begin
          pred_n = in_data;
          have_n = 1'b1;
          if (match) begin
            match_n = match_inc;
            if (match_inc == MCW'(LOCK_COUNT)) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            match_n = '0;
          end
        end
        LOCKED: begin
          wc_n   = (word_count == '1) ? word_count : word_count + CNT_W'(1);
          // Free-running prediction: a corrupted word does not disturb the base.
          pred_n = expected;
          if (match) begin
            miss_n = '0;
          end else begin
            pulse_n = 1'b1;
            ew_n    = (err_word_count == '1) ? err_word_count : err_word_count + CNT_W'(1);
            eb_n    = (bit_sum > CNT_MAX_EXT) ? '1 : bit_sum[CNT_W-1:0];
            miss_n  = miss_inc;
            if (miss_inc == UCW'(UNLOCK_COUNT)) begin
              state_n = HUNT;
              match_n = '0;
              pred_n  = in_data;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end

    if (clear_counts) begin
      ew_n = '0;
      eb_n = '0;
      wc_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      pred_base      <= '0;
      have_base      <= 1'b0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      err_word_count <= '0;
      err_bit_count  <= '0;
      word_count     <= '0;
      err_pulse      <= 1'b0;
    end else begin
      state          <= state_n;
      pred_base      <= pred_n;
      have_base      <= have_n;
      match_cnt      <= match_n;
      miss_cnt       <= miss_n;
      err_word_count <= ew_n;
      err_bit_count  <= eb_n;
      word_count     <= wc_n;
      err_pulse      <= pulse_n;
    end
  end

endmodule

// File: doc/prbs32_checker.md
# prbs32_checker

Self-synchronising checker for the 32-bit pseudo-random word stream produced by the PHY's 32-bit LFSR generator, used on the pcie_phy_core receive/loopback path for link BER testing. It seeds a local predictor from received words, declares lock after a run of correct predictions, then counts word and bit errors against its own free-running prediction. Counters are saturating and software-clearable.

## Interface
Parameters:
- LOCK_COUNT, 8: consecutive correct predictions needed to enter LOCKED (≥1)
- UNLOCK_COUNT, 4: consecutive mispredicted words in LOCKED that force HUNT (≥1)
- CNT_W, 32: width of all statistics counters

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  32  received word
- in_valid  in  1  in_data is a stream word this cycle; when low, state is frozen
- clear_counts  in  1  synchronous clear of all statistics counters
- locked  out  1  checker in LOCKED state
- err_pulse  out  1  one-cycle pulse: the previous cycle's valid word mismatched while LOCKED
- err_word_count  out  CNT_W  mismatched words while LOCKED, saturating
- err_bit_count  out  CNT_W  total mismatched bits while LOCKED, saturating
- word_count  out  CNT_W  valid words checked while LOCKED, saturating

## Operation
- Prediction function P(w): P[31:1] = w[30:0]; P[0] = w[30] ^ w[28] ^ w[24] ^ w[23]. This is the generator's exact next-word relation.
- Internal state: pred_base[31:0], have_base (1 bit), state ∈ {HUNT, LOCKED}, match_cnt, miss_cnt.
- Per valid word: expected = P(pred_base); match = have_base && (in_data == expected) && (in_data != 0). All-zero is a generator fixed point and is never a match.
- HUNT:
  - match: match_cnt+1; when it reaches LOCK_COUNT, go LOCKED with miss_cnt = 0.
  - no match: match_cnt = 0.
  - Always: pred_base = in_data, have_base = 1.
  - No counters change and err_pulse stays low.
- LOCKED:
  - Every valid word: word_count+1.
  - Match: miss_cnt = 0.
  - Mismatch: err_pulse, err_word_count+1, err_bit_count + popcount(in_data ^ expected), miss_cnt+1.
  - pred_base = expected on both match and mismatch. Local prediction free-runs, so one corrupted word costs exactly one error.
  - When miss_cnt reaches UNLOCK_COUNT: go HUNT, match_cnt = 0, pred_base = in_data. The counters still record that word.
- Saturation: each counter clamps at 2^CNT_W−1. The bit-count add is computed at CNT_W+6 bits, then clamped.
- clear_counts zeroes all three counters. If a clear and an increment land in the same cycle, the clear wins. Lock state is unaffected.
- in_valid low: no state, counter or pulse change; err_pulse is low.

## Timing
- Reset values: locked=0, err_pulse=0, all counters 0, state HUNT, have_base=0, match_cnt=0, miss_cnt=0, pred_base=0.
- Reset asserted mid-operation clears everything immediately (asynchronously) and loses lock. The first valid word after release only seeds pred_base.
- Latency:
  - All outputs are registered and reflect the valid word from the previous cycle.
  - locked rises on the cycle after the LOCK_COUNT-th consecutive match; minimum LOCK_COUNT+1 valid words after reset.
  - locked falls on the cycle after the UNLOCK_COUNT-th consecutive mismatch.
- Throughput: one word per cycle, no backpressure.
- Popcount and compare are single-cycle combinational on in_data; pipelining is not permitted because it would break the 1-cycle output latency.

## Test plan
- Lock acquisition: after reset, feed the generator sequence from seed 0x00000001 (0x1, 0x2, 0x4 … 0x00800000, 0x01000001, …), one per cycle, defaults → locked rises the cycle after word 9; all counters 0; err_pulse never high.
- Single-bit error: once locked, XOR one word with 0x00000010, then resume the clean sequence → one err_pulse; err_word_count=1, err_bit_count=1; locked stays 1; following words match.
- Loss of lock: once locked, feed 4 consecutive 0xFFFFFFFF → err_word_count=4; err_bit_count = Σ popcount(~expected); locked falls the cycle after the 4th; a clean sequence then relocks after 8 further matches.
- All-zero stream: 20 valid 0x00000000 words after reset → locked never asserts; counters stay 0.
- in_valid gaps and clear: locked stream with in_valid toggling every other cycle → no errors, and word_count equals the number of valid cycles. Then assert clear_counts in the same cycle as a corrupted word → all counters 0 afterwards and err_pulse still fires.
- Saturation and async reset: CNT_W=4, 20 corrupted words with UNLOCK_COUNT=32 → err_word_count holds at 15 and err_bit_count holds at 15. Then assert rst mid-cycle → all outputs 0 immediately.
